// File: rtl/muldiv_ctrl_pkg.sv
// HI/LO unit shared definitions: op encodings and controller states.
// Imported by the HI/LO controller and its storage sub-module.
package muldiv_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_reg.sv
// HI/LO architectural register pair with independent write enables.
// Ports: clk/rst, hi_we_i/lo_we_i, hi_d_i/lo_d_i in; hi_o/lo_o out.
module muldiv_ctrl_hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hi_d_i,
  input  logic [31:0] lo_d_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= hi_d_i;
      if (lo_we_i) lo_q <= lo_d_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: commits MULT/MT* at once, sequences external divider.
// Ports: op/operands/flush/hold in; divider handshake, stall, hi/lo out.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        pipe_hold,
  input  logic [63:0] mul_result,
  output logic        mul_sign,
  output logic        div_start,
  output logic        div_sign,
  output logic        div_abort,
  input  logic        div_done,
  input  logic [63:0] div_result,
  output logic        muldiv_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_timeout_err
);

  localparam int CW = (DIV_TIMEOUT < 2) ? 1
                    : $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic          err_q, err_d;

  logic          accept;
  logic          start, abort, stall;
  logic          hi_we, lo_we;
  logic [31:0]   hi_wd, lo_wd;

  // Divisor only travels to the external divider.
  logic          unused_src_b;
  assign unused_src_b = ^src_b;

  assign accept = op_valid & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    err_d   = err_q;
    start   = 1'b0;
    abort   = 1'b0;
    stall   = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_wd   = src_a;
    lo_wd   = src_a;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          case (op)
            OP_DIV, OP_DIVU: begin
              start   = 1'b1;
              stall   = 1'b1;
              sign_d  = (op == OP_DIV);
              state_d = ST_BUSY;
            end
            OP_MULT, OP_MULTU: begin
              hi_we = 1'b1;
              lo_we = 1'b1;
              hi_wd = mul_result[63:32];
              lo_wd = mul_result[31:0];
            end
            OP_MTHI: hi_we = 1'b1;
            OP_MTLO: lo_we = 1'b1;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        stall = 1'b1;
        // Flush beats a same-cycle done; done beats the watchdog.
        if (flush) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (div_done) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_wd   = div_result[63:32];
          lo_wd   = div_result[31:0];
          stall   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        // Divide result already committed; wait for EX to move on.
        if (flush || !pipe_hold) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  muldiv_ctrl_hilo_reg u_hilo (
    .clk     (clk),
    .rst     (rst),
    .hi_we_i (hi_we & ~rst),
    .lo_we_i (lo_we & ~rst),
    .hi_d_i  (hi_wd),
    .lo_d_i  (lo_wd),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // Handshake outputs are forced quiet while reset is held.
  assign div_start       = start & ~rst;
  assign div_abort       = abort & ~rst;
  assign muldiv_stall    = stall & ~rst;
  // Divider samples the sign together with the start pulse.
  assign div_sign        = div_start ? (op == OP_DIV) : sign_q;
  assign mul_sign        = (op == OP_MULT);
  assign div_timeout_err = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for the HI/LO controller.
// Divider handshake is driven by hand per scenario.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush, pipe_hold;
  logic [63:0] mul_result;
  logic        mul_sign, div_start, div_sign, div_abort;
  logic        div_done;
  logic [63:0] div_result;
  logic        muldiv_stall;
  logic [31:0] hi, lo;
  logic        div_timeout_err;

  int checks = 0;
  int errors = 0;
  int starts, stalls, both, abort_at;

  always #5 clk = ~clk;

  muldiv_ctrl #(.DIV_TIMEOUT(40)) dut (
    .clk             (clk),
    .rst             (rst),
    .op_valid        (op_valid),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .flush           (flush),
    .pipe_hold       (pipe_hold),
    .mul_result      (mul_result),
    .mul_sign        (mul_sign),
    .div_start       (div_start),
    .div_sign        (div_sign),
    .div_abort       (div_abort),
    .div_done        (div_done),
    .div_result      (div_result),
    .muldiv_stall    (muldiv_stall),
    .hi              (hi),
    .lo              (lo),
    .div_timeout_err (div_timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sim time expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    op_valid   = 1'b1;
    op         = OP_DIV;
    src_a      = 32'd5;
    src_b      = 32'd1;
    flush      = 1'b0;
    pipe_hold  = 1'b0;
    mul_result = '0;
    div_done   = 1'b0;
    div_result = '0;
    #1;
    chk("rst_start", div_start, 1'b0);
    chk("rst_abort", div_abort, 1'b0);
    chk("rst_stall", muldiv_stall, 1'b0);
    tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_err", div_timeout_err, 1'b0);
    chk("rst_sign", div_sign, 1'b0);
    rst      = 1'b0;
    op_valid = 1'b0;
    tick();

    // MULT signed
    op_valid   = 1'b1;
    op         = OP_MULT;
    src_a      = 32'hFFFF_FFFE;
    src_b      = 32'd3;
    mul_result = 64'hFFFF_FFFF_FFFF_FFFA;
    #1;
    chk("mult_stall", muldiv_stall, 1'b0);
    chk("mult_sign", mul_sign, 1'b1);
    chk("mult_nobypass", hi, 32'h0);
    tick();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU with op_valid low: sign 0, no commit
    op_valid   = 1'b0;
    op         = OP_MULTU;
    mul_result = 64'h1111_2222_3333_4444;
    #1;
    chk("multu_sign", mul_sign, 1'b0);
    tick();
    chk("novalid_hi", hi, 32'hFFFF_FFFF);

    // MTHI killed by flush
    op_valid = 1'b1;
    op       = OP_MTHI;
    src_a    = 32'hDEAD_BEEF;
    flush    = 1'b1;
    tick();
    chk("flush_mthi", hi, 32'hFFFF_FFFF);
    flush = 1'b0;

    // MTHI then MTLO
    src_a = 32'h1234_5678;
    tick();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'hFFFF_FFFA);
    op    = OP_MTLO;
    src_a = 32'h9ABC_DEF0;
    tick();
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);

    // DIVU 100/7, done 33 cycles after start
    op         = OP_DIVU;
    src_a      = 32'd100;
    src_b      = 32'd7;
    div_result = {32'd2, 32'd14};
    starts     = 0;
    stalls     = 0;
    for (int k = 0; k <= 33; k++) begin
      div_done = (k == 33);
      #1;
      if (k == 0) chk("divu_sign", div_sign, 1'b0);
      starts += int'(div_start);
      stalls += int'(muldiv_stall);
      tick();
    end
    chk("divu_starts", starts, 1);
    chk("divu_stalls", stalls, 33);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);
    op_valid = 1'b0;
    div_done = 1'b0;
    #1;
    chk("divu_done_stall", muldiv_stall, 1'b0);
    tick();

    // DIV flushed at cycle 10, with a colliding done
    op_valid   = 1'b1;
    op         = OP_DIV;
    src_a      = 32'hFFFF_FF9C;
    div_result = 64'h5555_5555_6666_6666;
    for (int k = 0; k <= 10; k++) begin
      flush    = (k == 10);
      div_done = (k == 10);
      #1;
      if (k == 0) chk("div_start0", div_start, 1'b1);
      if (k == 0) chk("div_sign0", div_sign, 1'b1);
      if (k == 5) chk("div_sign_hold", div_sign, 1'b1);
      if (k == 10) begin
        chk("flush_abort", div_abort, 1'b1);
        chk("flush_nostart", div_start, 1'b0);
      end
      tick();
    end
    flush    = 1'b0;
    div_done = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("flush_stall_drop", muldiv_stall, 1'b0);
    chk("flush_abort_once", div_abort, 1'b0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);
    tick();

    // Done under pipe_hold for 5 cycles
    op_valid = 1'b1;
    op       = OP_DIVU;
    starts   = 0;
    stalls   = 0;
    for (int k = 0; k <= 9; k++) begin
      pipe_hold  = (k >= 4) && (k <= 8);
      div_done   = (k == 4) || (k == 6);
      div_result = (k == 4) ? {32'd7, 32'd9}
                            : 64'hAAAA_AAAA_BBBB_BBBB;
      #1;
      starts += int'(div_start);
      if (k >= 4) stalls += int'(muldiv_stall);
      tick();
    end
    chk("hold_starts", starts, 1);
    chk("hold_stalls", stalls, 0);
    chk("hold_hi", hi, 32'd7);
    chk("hold_lo", lo, 32'd9);
    op_valid = 1'b0;
    div_done = 1'b0;
    tick();

    // Watchdog: divider never answers
    op_valid = 1'b1;
    op       = OP_DIV;
    abort_at = -1;
    both     = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (div_abort && div_start) both++;
      if (div_abort && abort_at < 0) abort_at = k;
      tick();
      if (abort_at >= 0) break;
    end
    op_valid = 1'b0;
    chk("wdog_cycle", 64'(abort_at), 64'(40));
    chk("wdog_err", div_timeout_err, 1'b1);
    chk("wdog_hi", hi, 32'd7);
    chk("wdog_lo", lo, 32'd9);
    chk("start_abort_excl", both, 0);
    #1;
    chk("wdog_stall_drop", muldiv_stall, 1'b0);
    tick();
    chk("wdog_sticky", div_timeout_err, 1'b1);

    // Reset in the middle of a divide
    op_valid = 1'b1;
    op       = OP_DIVU;
    tick();
    op_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_abort", div_abort, 1'b0);
    chk("mid_rst_stall", muldiv_stall, 1'b0);
    chk("mid_rst_err", div_timeout_err, 1'b0);
    chk("mid_rst_hi", hi, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("post_rst_idle", muldiv_stall, 1'b0);
    op_valid = 1'b1;
    op       = OP_MTLO;
    src_a    = 32'h0000_0055;
    tick();
    chk("post_rst_mtlo", lo, 32'h0000_0055);
    op_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
